// File: rtl/rec_pkg.sv
// Shared definitions for the beat-clocked note recorder transport:
// state encoding, counter width and default pitches.
package rec_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COUNTIN = 3'd1,
    S_REC     = 3'd2,
    S_PLAY    = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  localparam int unsigned CNT_W          = 9;
  localparam int unsigned REC_MAX_BEATS  = 511;
  localparam logic [31:0] DEF_CLICK_FREQ = 32'd1000;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one button level, sampled on the beat clock.
// The output is high for exactly one beat per press.
module btn_edge (
  input  logic beat,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic prev;

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge beat) begin
    if (reset) prev <= 1'b0;
    else       prev <= btn;
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/rec_play_ctrl.sv
// Transport sequencer for the note recorder: count-in, take, looped playback,
// and the speaker pitch mux.
module rec_play_ctrl
  import rec_pkg::*;
#(
  parameter int unsigned MAX_BEATS     = REC_MAX_BEATS,
  parameter int unsigned COUNTIN_BEATS = 4,
  parameter logic [31:0] CLICK_FREQ    = DEF_CLICK_FREQ,
  parameter int unsigned GAP_BEATS     = 2
) (
  input  logic             beat,
  input  logic             reset,
  input  logic             rec_btn,
  input  logic             play_btn,
  input  logic             stop_btn,
  input  logic             loop_en,
  input  logic [31:0]      freq_key,
  input  logic [31:0]      freq_rec,
  output logic             rec_begin,
  output logic             rec_play,
  output logic [31:0]      freq_out,
  output logic [CNT_W-1:0] take_len,
  output logic [2:0]       state_o
);

  localparam logic [CNT_W-1:0] COUNTIN_LAST = CNT_W'(COUNTIN_BEATS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_BEATS - 1);
  localparam logic [CNT_W-1:0] LEN_MAX      = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, len, pcnt;
  logic             rec_e, play_e, stop_e;

  btn_edge u_rec_edge  (.beat(beat), .reset(reset), .btn(rec_btn),  .rise(rec_e));
  btn_edge u_play_edge (.beat(beat), .reset(reset), .btn(play_btn), .rise(play_e));
  btn_edge u_stop_edge (.beat(beat), .reset(reset), .btn(stop_btn), .rise(stop_e));

  // Recorder controls are decoded from next_state so they move with state_o.
  always_ff @(posedge beat) begin
    if (reset) begin
      state     <= S_IDLE;
      rec_begin <= 1'b0;
      rec_play  <= 1'b0;
    end else begin
      state     <= next_state;
      rec_begin <= (next_state == S_REC);
      rec_play  <= (next_state == S_PLAY);
    end
  end

  // NOTE: take_len is cleared on reset as well, since recorder memory is no longer trusted.
  always_ff @(posedge beat) begin
    if (reset) begin
      cnt      <= '0;
      len      <= '0;
      pcnt     <= '0;
      take_len <= '0;
    end else begin
      if (next_state != state)                        cnt <= '0;
      else if (state == S_COUNTIN || state == S_GAP)  cnt <= cnt + ONE;
      len  <= (state == S_REC  && next_state == S_REC)  ? len + ONE  : '0;
      pcnt <= (state == S_PLAY && next_state == S_PLAY) ? pcnt + ONE : '0;
      if (state == S_REC && next_state != S_REC) take_len <= len;
    end
  end

  // NOTE: next_state gets a default before the case so no path infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (!stop_e) begin
          if (rec_e)                           next_state = S_COUNTIN;
          else if (play_e && take_len != '0)   next_state = S_PLAY;
        end
      end
      S_COUNTIN: begin
        if (stop_e)                    next_state = S_IDLE;
        else if (cnt == COUNTIN_LAST)  next_state = S_REC;
      end
      S_REC: begin
        if (stop_e || rec_e || len == LEN_MAX) next_state = S_IDLE;
      end
      S_PLAY: begin
        if (stop_e || play_e)      next_state = S_IDLE;
        else if (pcnt == take_len) next_state = loop_en ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (stop_e)                next_state = S_IDLE;
        else if (cnt == GAP_LAST)  next_state = loop_en ? S_PLAY : S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    freq_out = freq_key;
    unique case (state)
      S_COUNTIN: freq_out = cnt[0] ? 32'd0 : CLICK_FREQ;
      S_PLAY:    freq_out = freq_rec;
      S_GAP:     freq_out = 32'd0;
      default:   freq_out = freq_key;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Directed bench for rec_play_ctrl: count-in, take, single and looped playback,
// ignored commands, take-length saturation and reset mid-take.
module tb_rec_play_ctrl;

  logic        beat = 1'b0;
  logic        reset;
  logic        rec_btn, play_btn, stop_btn, loop_en;
  logic [31:0] freq_key, freq_rec, freq_out;
  logic        rec_begin, rec_play;
  logic [8:0]  take_len;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  rec_play_ctrl dut (
    .beat(beat), .reset(reset), .rec_btn(rec_btn), .play_btn(play_btn),
    .stop_btn(stop_btn), .loop_en(loop_en), .freq_key(freq_key), .freq_rec(freq_rec),
    .rec_begin(rec_begin), .rec_play(rec_play), .freq_out(freq_out),
    .take_len(take_len), .state_o(state_o)
  );

  always #5 beat = ~beat;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge beat);
      #1;
    end
  endtask

  // which: 0 = rec, 1 = play, 2 = stop
  task automatic press(input int which);
    case (which)
      0: rec_btn  = 1'b1;
      1: play_btn = 1'b1;
      default: stop_btn = 1'b1;
    endcase
    tick();
    rec_btn = 1'b0; play_btn = 1'b0; stop_btn = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; tick(2); reset = 1'b0;
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_o); end
    checks++; if (rec_begin !== 1'b0 || rec_play !== 1'b0) begin errors++; $display("FAIL reset_ctl: got begin=%b play=%b want 0/0", rec_begin, rec_play); end
    checks++; if (take_len !== 9'd0) begin errors++; $display("FAIL reset_len: got %0d want 0", take_len); end
    checks++; if (freq_out !== 32'd440) begin errors++; $display("FAIL reset_freq: got %0d want 440", freq_out); end
    freq_key = 32'd523; #1;
    checks++; if (freq_out !== 32'd523) begin errors++; $display("FAIL idle_key_mux: got %0d want 523", freq_out); end
    freq_key = 32'd440; #1;
  endtask

  task automatic test_countin;
    logic [31:0] exp_f;
    press(0);
    for (int i = 0; i < 4; i++) begin
      exp_f = (i % 2 == 0) ? 32'd1000 : 32'd0;
      checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL countin_state[%0d]: got %0d want 1", i, state_o); end
      checks++; if (freq_out !== exp_f) begin errors++; $display("FAIL countin_click[%0d]: got %0d want %0d", i, freq_out, exp_f); end
      checks++; if (rec_begin !== 1'b0) begin errors++; $display("FAIL countin_begin[%0d]: got %b want 0", i, rec_begin); end
      tick();
    end
    checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL rec_entry_state: got %0d want 2", state_o); end
    checks++; if (rec_begin !== 1'b1) begin errors++; $display("FAIL rec_entry_begin: got %b want 1", rec_begin); end
    checks++; if (freq_out !== 32'd440) begin errors++; $display("FAIL rec_freq: got %0d want 440", freq_out); end
  endtask

  task automatic test_record;
    tick(10);
    checks++; if (state_o !== 3'd2 || rec_begin !== 1'b1) begin errors++; $display("FAIL rec_hold: got state=%0d begin=%b want 2/1", state_o, rec_begin); end
    press(2);
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL rec_stop_state: got %0d want 0", state_o); end
    checks++; if (take_len !== 9'd10) begin errors++; $display("FAIL rec_take_len: got %0d want 10", take_len); end
    checks++; if (rec_begin !== 1'b0) begin errors++; $display("FAIL rec_stop_begin: got %b want 0", rec_begin); end
  endtask

  task automatic test_play_once;
    loop_en = 1'b0;
    press(1);
    for (int i = 0; i <= 10; i++) begin
      checks++; if (state_o !== 3'd3 || rec_play !== 1'b1 || rec_begin !== 1'b0) begin errors++; $display("FAIL play_once[%0d]: got state=%0d play=%b begin=%b want 3/1/0", i, state_o, rec_play, rec_begin); end
      checks++; if (freq_out !== 32'd880) begin errors++; $display("FAIL play_freq[%0d]: got %0d want 880", i, freq_out); end
      tick();
    end
    checks++; if (state_o !== 3'd0 || rec_play !== 1'b0) begin errors++; $display("FAIL play_end: got state=%0d play=%b want 0/0", state_o, rec_play); end
  endtask

  task automatic test_loop;
    loop_en = 1'b1;
    press(1);
    checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL loop_start: got %0d want 3", state_o); end
    tick(11);
    for (int i = 0; i < 2; i++) begin
      checks++; if (state_o !== 3'd4 || rec_play !== 1'b0 || freq_out !== 32'd0) begin errors++; $display("FAIL loop_gap[%0d]: got state=%0d play=%b freq=%0d want 4/0/0", i, state_o, rec_play, freq_out); end
      tick();
    end
    checks++; if (state_o !== 3'd3 || rec_play !== 1'b1 || freq_out !== 32'd880) begin errors++; $display("FAIL loop_restart: got state=%0d play=%b freq=%0d want 3/1/880", state_o, rec_play, freq_out); end
    tick(3);
    press(0);
    checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL play_rec_ignored: got %0d want 3", state_o); end
    press(2);
    checks++; if (state_o !== 3'd0 || rec_play !== 1'b0) begin errors++; $display("FAIL loop_stop: got state=%0d play=%b want 0/0", state_o, rec_play); end
    press(1);
    tick(11);
    loop_en = 1'b0;
    tick();
    checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL gap_completes: got %0d want 4", state_o); end
    tick();
    checks++; if (state_o !== 3'd0 || rec_play !== 1'b0) begin errors++; $display("FAIL gap_to_idle: got state=%0d play=%b want 0/0", state_o, rec_play); end
  endtask

  task automatic test_ignored;
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (take_len !== 9'd0) begin errors++; $display("FAIL reset_clears_len: got %0d want 0", take_len); end
    press(1);
    checks++; if (state_o !== 3'd0 || rec_play !== 1'b0) begin errors++; $display("FAIL play_empty: got state=%0d play=%b want 0/0", state_o, rec_play); end
    rec_btn = 1'b1; play_btn = 1'b1; stop_btn = 1'b1;
    tick();
    rec_btn = 1'b0; play_btn = 1'b0; stop_btn = 1'b0;
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL stop_priority: got %0d want 0", state_o); end
    tick();
  endtask

  task automatic test_overflow;
    press(0);
    tick(4);
    checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL ovf_rec_entry: got %0d want 2", state_o); end
    tick(511);
    checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL ovf_still_rec: got %0d want 2", state_o); end
    tick();
    checks++; if (state_o !== 3'd0 || rec_begin !== 1'b0) begin errors++; $display("FAIL ovf_autostop: got state=%0d begin=%b want 0/0", state_o, rec_begin); end
    checks++; if (take_len !== 9'd511) begin errors++; $display("FAIL ovf_take_len: got %0d want 511", take_len); end
    press(0);
    tick(7);
    checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL midrec_state: got %0d want 2", state_o); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (state_o !== 3'd0 || take_len !== 9'd0) begin errors++; $display("FAIL midrec_reset: got state=%0d len=%0d want 0/0", state_o, take_len); end
    checks++; if (rec_begin !== 1'b0 || rec_play !== 1'b0 || freq_out !== 32'd440) begin errors++; $display("FAIL midrec_outputs: got begin=%b play=%b freq=%0d want 0/0/440", rec_begin, rec_play, freq_out); end
  endtask

  initial begin
    reset = 1'b1; rec_btn = 1'b0; play_btn = 1'b0; stop_btn = 1'b0; loop_en = 1'b0;
    freq_key = 32'd440; freq_rec = 32'd880;
    test_reset();
    test_countin();
    test_record();
    test_play_once();
    test_loop();
    test_ignored();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
